// File: rtl/lcd_timing_gen.sv
// Raster timing and test-pattern generator for an LVDS LCD panel.
// Sync and pixel outputs are all registered, one clock behind the h/v counters.
module lcd_timing_gen #(
    parameter int unsigned H_ACTIVE = 1024,
    parameter int unsigned H_FP     = 24,
    parameter int unsigned H_SYNC   = 136,
    parameter int unsigned H_BP     = 160,
    parameter int unsigned V_ACTIVE = 768,
    parameter int unsigned V_FP     = 3,
    parameter int unsigned V_SYNC   = 6,
    parameter int unsigned V_BP     = 29,
    parameter logic        SYNC_POL = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [1:0]  mode,
    input  logic [23:0] solid_rgb,
    output logic [7:0]  r,
    output logic [7:0]  g,
    output logic [7:0]  b,
    output logic        HSYNC,
    output logic        VSYNC,
    output logic        DEN,
    output logic        frame_start
);

    localparam logic [11:0] H_ACT      = 12'(H_ACTIVE);
    localparam logic [11:0] H_SYNC_BEG = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] H_SYNC_END = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [11:0] H_LAST     = 12'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [11:0] V_ACT      = 12'(V_ACTIVE);
    localparam logic [11:0] V_SYNC_BEG = 12'(V_ACTIVE + V_FP);
    localparam logic [11:0] V_SYNC_END = 12'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [11:0] V_LAST     = 12'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [11:0] BAR_W      = 12'(H_ACTIVE / 8);

    typedef enum logic [1:0] {
        PAT_BARS  = 2'd0,
        PAT_RAMP  = 2'd1,
        PAT_CHECK = 2'd2,
        PAT_SOLID = 2'd3
    } pattern_e;

    logic [11:0] h_cnt;
    logic [11:0] v_cnt;
    pattern_e    mode_sh;
    logic [23:0] solid_sh;

    logic        frame_origin;
    pattern_e    mode_eff;
    logic [23:0] solid_eff;
    logic        den_c;
    logic        hs_c;
    logic        vs_c;
    logic [2:0]  bar;
    logic [23:0] pat_c;
    logic [23:0] rgb_c;

    // At the frame origin the shadows are being loaded on this same edge, so
    // pixel (0,0) takes the live inputs to keep the whole frame consistent.
    always_comb begin
        frame_origin = (h_cnt == '0) && (v_cnt == '0);
        mode_eff     = frame_origin ? pattern_e'(mode) : mode_sh;
        solid_eff    = frame_origin ? solid_rgb : solid_sh;

        den_c = (h_cnt < H_ACT) && (v_cnt < V_ACT);
        hs_c  = (h_cnt >= H_SYNC_BEG) && (h_cnt < H_SYNC_END);
        vs_c  = (v_cnt >= V_SYNC_BEG) && (v_cnt < V_SYNC_END);
        bar   = 3'(h_cnt / BAR_W);

        pat_c = '0;
        unique case (mode_eff)
            PAT_BARS: begin
                unique case (bar)
                    3'd0: pat_c = 24'hFFFFFF;
                    3'd1: pat_c = 24'hFFFF00;
                    3'd2: pat_c = 24'h00FFFF;
                    3'd3: pat_c = 24'h00FF00;
                    3'd4: pat_c = 24'hFF00FF;
                    3'd5: pat_c = 24'hFF0000;
                    3'd6: pat_c = 24'h0000FF;
                    3'd7: pat_c = 24'h000000;
                    default: pat_c = '0;
                endcase
            end
            PAT_RAMP:  pat_c = {h_cnt[7:0], h_cnt[7:0], h_cnt[7:0]};
            PAT_CHECK: pat_c = (h_cnt[5] ^ v_cnt[5]) ? '1 : '0;
            PAT_SOLID: pat_c = solid_eff;
            default:   pat_c = '0;
        endcase

        rgb_c = den_c ? pat_c : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            h_cnt       <= '0;
            v_cnt       <= '0;
            mode_sh     <= PAT_BARS;
            solid_sh    <= '0;
            {r, g, b}   <= '0;
            DEN         <= 1'b0;
            frame_start <= 1'b0;
            HSYNC       <= ~SYNC_POL;
            VSYNC       <= ~SYNC_POL;
        end else if (en) begin
            if (h_cnt == H_LAST) begin
                h_cnt <= '0;
                v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 12'd1;
            end else begin
                h_cnt <= h_cnt + 12'd1;
            end

            if (frame_origin) begin
                mode_sh  <= pattern_e'(mode);
                solid_sh <= solid_rgb;
            end

            {r, g, b}   <= rgb_c;
            DEN         <= den_c;
            frame_start <= frame_origin;
            HSYNC       <= hs_c ? SYNC_POL : ~SYNC_POL;
            VSYNC       <= vs_c ? SYNC_POL : ~SYNC_POL;
        end else begin
            {r, g, b}   <= '0;
            DEN         <= 1'b0;
            frame_start <= 1'b0;
            HSYNC       <= ~SYNC_POL;
            VSYNC       <= ~SYNC_POL;
        end
    end

endmodule

// File: doc/lcd_timing_gen.md
LCD_TIMING_GEN -- requirements
Module: lcd_timing_gen

Interface
REQ-001 Parameter H_ACTIVE, default 1024, active pixels per line; SHALL be a multiple of 8.
REQ-002 Parameter H_FP, default 24; H_SYNC, default 136; H_BP, default 160. These are horizontal porch and sync widths in pixel clocks.
REQ-003 Parameter V_ACTIVE, default 768; V_FP, default 3; V_SYNC, default 6; V_BP, default 29. These are vertical line counts.
REQ-004 Parameter SYNC_POL, default 0: polarity of the asserted HSYNC/VSYNC level (0 = active-low).
REQ-005 clk  input  1  pixel clock; the only clock; all logic is on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 en  input  1  run enable; low freezes the raster position.
REQ-008 mode  input  2  pattern select: 0 colour bars, 1 grey ramp, 2 checkerboard, 3 solid.
REQ-009 solid_rgb  input  24  solid colour {r,g,b}, used when mode=3.
REQ-010 r, g, b  output  8 each  pixel colour fed to the LVDS transmitter.
REQ-011 HSYNC, VSYNC, DEN  output  1 each  line sync, frame sync, data enable.
REQ-012 frame_start  output  1  one-cycle pulse coincident with the first active pixel of each frame.

Function
REQ-013 h_cnt SHALL count 0..H_TOTAL-1, where H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP, then wrap to 0; it advances once per clk while en=1.
REQ-014 v_cnt SHALL count 0..V_TOTAL-1 (V_TOTAL analogous) and wrap; it advances only on the cycle where h_cnt wraps.
REQ-015 Counters SHALL be 12 bits; totals up to 4095 SHALL be supported without overflow.
REQ-016 Line order SHALL be active, front porch, sync, back porch; frame order SHALL be the same in lines.
REQ-017 Pre-register DEN SHALL be 1 iff h_cnt<H_ACTIVE and v_cnt<V_ACTIVE.
REQ-018 HSYNC SHALL be asserted iff H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC.
REQ-019 VSYNC SHALL be asserted iff V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC; its transitions SHALL be aligned to h_cnt=0.
REQ-020 All outputs SHALL be registered with a latency of exactly 1 clk from counter state; r/g/b/DEN/HSYNC/VSYNC SHALL be mutually aligned.
REQ-021 When DEN=0, r/g/b SHALL be 0.
REQ-022 Mode 0: bar index = h_cnt/(H_ACTIVE/8). Bars 0..7 SHALL be white, yellow, cyan, green, magenta, red, blue, black; each channel is 0xFF or 0x00.
REQ-023 Mode 1: r=g=b=h_cnt[7:0].
REQ-024 Mode 2: r=g=b=0xFF if h_cnt[5]^v_cnt[5], else 0x00.
REQ-025 Mode 3: {r,g,b}=solid_rgb.
REQ-026 mode and solid_rgb SHALL be sampled into shadow registers only when h_cnt=0, v_cnt=0 and en=1, so a change takes effect at the next frame start with no mid-frame tearing.
REQ-027 frame_start SHALL be 1 for exactly the one cycle where output DEN is first high in a frame (counter state h=0, v=0).
REQ-028 en=0: counters and shadow registers SHALL hold. Output DEN and frame_start SHALL be 0, HSYNC/VSYNC SHALL be inactive, and r/g/b SHALL be 0, from the next clk. On re-assertion, the raster SHALL resume from the held position.

Reset
REQ-029 reset=1 SHALL, at the next clk edge, set h_cnt=0, v_cnt=0, shadow mode=0, shadow solid=0, r=g=b=0, DEN=0, frame_start=0, HSYNC=VSYNC=~SYNC_POL (inactive).
REQ-030 reset SHALL take priority over en. Reset asserted mid-line SHALL abort the frame; the first output cycle after release with en=1 SHALL be pixel (0,0) with frame_start=1.

Verification (bench params H 16/2/3/3 = 24, V 4/1/2/1 = 8, SYNC_POL=0, so one frame = 192 clk)
REQ-031 Release reset, en=1, mode=0 -> the first output cycle has frame_start=1, DEN=1, rgb=FFFFFF. Bars change every 2 pixels, ending with 000000 at pixels 14-15. DEN is high for 16 clk then low for 8.
REQ-032 Free run -> HSYNC is low for exactly 3 clk starting 18 clk after DEN rises. VSYNC is low for 48 clk starting at the start of line 5. frame_start period is 192 clk.
REQ-033 mode changed 0->3 (solid_rgb=123456) mid-frame -> the remaining frame still shows bars; the next frame shows 123456 on all active pixels.
REQ-034 en low for 10 clk during active video -> DEN, r/g/b and frame_start are 0 and syncs are high during the gap. The pixel after re-enable is the held next pixel value, and the frame length excluding the gap is still 192.
REQ-035 reset pulsed for 1 clk at pixel (h=20, v=5) -> all outputs are at reset values the cycle after. Restart at (0,0) with frame_start=1.
REQ-036 mode=1 and mode=2 for one frame -> r=g=b=h_cnt on active pixels. Checkerboard is all 0x00 for the bench size (h,v<32). Both are zero in blanking.
